// File: rtl/bp_fe_fetch_buffer.sv
// Multi-lane fetch buffer: compacts up to fetch_width_p instructions per packet into a
// circular buffer and issues one entry per cycle to the back end.
module bp_fe_fetch_buffer #(
  parameter int vaddr_width_p    = 39,
  parameter int instr_width_p    = 32,
  parameter int fetch_width_p    = 2,
  parameter int els_p            = 8,
  parameter int metadata_width_p = 36
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   fetch_v_i,
  output logic                                   fetch_ready_o,
  input  logic [vaddr_width_p-1:0]               fetch_pc_i,
  input  logic [fetch_width_p*instr_width_p-1:0] fetch_instr_i,
  input  logic [fetch_width_p-1:0]               fetch_mask_i,
  input  logic [metadata_width_p-1:0]            fetch_metadata_i,
  input  logic                                   fetch_exception_v_i,
  input  logic [1:0]                             fetch_exception_code_i,
  input  logic                                   poison_i,
  output logic                                   fe_v_o,
  input  logic                                   fe_ready_i,
  output logic [vaddr_width_p-1:0]               fe_pc_o,
  output logic [instr_width_p-1:0]               fe_instr_o,
  output logic [metadata_width_p-1:0]            fe_metadata_o,
  output logic                                   fe_exception_v_o,
  output logic [1:0]                             fe_exception_code_o,
  output logic [$clog2(els_p+1)-1:0]             occupancy_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  typedef enum logic {e_run, e_stall} state_e;

  state_e                state_q, state_d;
  logic [ptr_w_lp-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ptr_w_lp-1:0]   wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0]   count_q, count_d;

  logic [vaddr_width_p-1:0]    pc_mem    [els_p];
  logic [instr_width_p-1:0]    instr_mem [els_p];
  logic [metadata_width_p-1:0] meta_mem  [els_p];
  logic                        exc_v_mem [els_p];
  logic [1:0]                  exc_c_mem [els_p];

  logic [ptr_w_lp-1:0] lane_idx [fetch_width_p];
  logic [cnt_w_lp-1:0] pkt_cnt;
  logic [cnt_w_lp-1:0] written;
  logic [cnt_w_lp-1:0] free_cnt;
  logic                enq, deq;

  // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
  always_comb begin
    pkt_cnt = '0;
    for (int k = 0; k < fetch_width_p; k++) begin
      lane_idx[k] = wr_ptr_q + ptr_w_lp'(pkt_cnt);
      pkt_cnt     = pkt_cnt + cnt_w_lp'(fetch_mask_i[k]);
    end
  end

  assign written  = fetch_exception_v_i ? cnt_w_lp'(1) : pkt_cnt;
  assign free_cnt = cnt_w_lp'(els_p) - count_q;

  assign fe_v_o = (count_q != '0) & ~poison_i;
  assign enq    = fetch_v_i & fetch_ready_o & ~poison_i;
  assign deq    = fe_v_o & fe_ready_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= e_run;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Stall is entered on an accepted exception and left only through a flush.
  always_comb begin
    state_d = state_q;
    if (poison_i) state_d = e_run;
    else if (enq && fetch_exception_v_i) state_d = e_stall;
  end

  always_comb begin
    fetch_ready_o = (state_q == e_run) && (free_cnt >= cnt_w_lp'(fetch_width_p));
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (poison_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + ptr_w_lp'(written);
      if (deq) rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
      count_d = count_q + (enq ? written : '0) - cnt_w_lp'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      if (fetch_exception_v_i) begin
        pc_mem[wr_ptr_q]    <= fetch_pc_i;
        instr_mem[wr_ptr_q] <= '0;
        meta_mem[wr_ptr_q]  <= fetch_metadata_i;
        exc_v_mem[wr_ptr_q] <= 1'b1;
        exc_c_mem[wr_ptr_q] <= fetch_exception_code_i;
      end else begin
        for (int k = 0; k < fetch_width_p; k++) begin
          if (fetch_mask_i[k]) begin
            pc_mem[lane_idx[k]]    <= fetch_pc_i + vaddr_width_p'(4 * k);
            instr_mem[lane_idx[k]] <= fetch_instr_i[k*instr_width_p +: instr_width_p];
            meta_mem[lane_idx[k]]  <= fetch_metadata_i;
            exc_v_mem[lane_idx[k]] <= 1'b0;
            exc_c_mem[lane_idx[k]] <= 2'b00;
          end
        end
      end
    end
  end

  assign fe_pc_o             = pc_mem[rd_ptr_q];
  assign fe_instr_o          = instr_mem[rd_ptr_q];
  assign fe_metadata_o       = meta_mem[rd_ptr_q];
  assign fe_exception_v_o    = exc_v_mem[rd_ptr_q];
  assign fe_exception_code_o = exc_c_mem[rd_ptr_q];
  assign occupancy_o         = count_q;

endmodule
